// File: rtl/maple_rx_frame_checker.sv
// Maple Bus RX frame checker.
// Takes the receiver's byte stream and checks each frame's length against the
// header word count and its XOR checksum. It removes the checksum byte and sends
// the header and payload on, with tlast/tuser marking the last payload byte.
// It also keeps saturating status counters.
module maple_rx_frame_checker #(
  parameter int LEN_IDX = 0,
  parameter int CNT_W   = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             enable,
  input  logic [7:0]       s_axis_tdata,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic [7:0]       m_axis_tdata,
  output logic             m_axis_tlast,
  output logic             m_axis_tuser,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             frame_done,
  output logic             crc_err,
  output logic             len_err,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] crc_err_count,
  output logic [CNT_W-1:0] len_err_count
);

  typedef enum logic {PASS, DROP} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t      state, state_nxt;
  logic [7:0]  hb;
  logic        hb_full;
  logic [10:0] cnt;
  logic [7:0]  xr;
  logic [7:0]  len;

  logic        acc, pass_acc, ck_acc, dat_acc;
  logic        hdr_done, is_ck, crc_bad, len_bad;
  logic [10:0] cnt_inc, exp_len;

  // Frame-length bookkeeping. exp_len is the total frame length including the
  // checksum byte. It is only meaningful once the 4-byte header has been
  // counted, and the length-based checksum detection is gated on that.
  assign cnt_inc  = cnt + 11'd1;
  assign exp_len  = {1'b0, len, 2'b00} + 11'd5;
  assign hdr_done = (cnt >= 11'd4);
  assign is_ck    = s_axis_tlast || (hdr_done && (cnt_inc == exp_len));
  assign crc_bad  = (s_axis_tdata != xr);
  assign len_bad  = !hdr_done || (cnt_inc != exp_len) || !s_axis_tlast;

  assign acc      = s_axis_tvalid && s_axis_tready;
  assign pass_acc = acc && (state == PASS);
  assign ck_acc   = pass_acc && is_ck;
  assign dat_acc  = pass_acc && !is_ck;

  // State register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= PASS;
    else          state <= state_nxt;
  end

  // Next state and input ready. DROP swallows bytes regardless of output space.
  always_comb begin
    state_nxt     = state;
    s_axis_tready = 1'b0;
    case (state)
      PASS: begin
        s_axis_tready = enable && (!m_axis_tvalid || m_axis_tready);
        if (ck_acc && !s_axis_tlast) state_nxt = DROP;
      end
      DROP: begin
        s_axis_tready = enable;
        if (acc && s_axis_tlast) state_nxt = PASS;
      end
      default: state_nxt = PASS;
    endcase
  end

  // Hold buffer, running XOR, byte count and captured word count.
  // A byte waits in hb until the next byte shows it is not the checksum.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      hb      <= 8'h00;
      hb_full <= 1'b0;
      cnt     <= 11'd0;
      xr      <= 8'h00;
      len     <= 8'h00;
    end else if (dat_acc) begin
      hb      <= s_axis_tdata;
      hb_full <= 1'b1;
      xr      <= xr ^ s_axis_tdata;
      cnt     <= cnt_inc;
      if (cnt == 11'(LEN_IDX)) len <= s_axis_tdata;
    end else if (ck_acc) begin
      hb_full <= 1'b0;
      cnt     <= 11'd0;
      xr      <= 8'h00;
    end
  end

  // Output register. Ready only allows input when ob is free or draining, so
  // loading ob from hb never overwrites an unsent byte.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= 8'h00;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;
      if (pass_acc && hb_full) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= hb;
        m_axis_tlast  <= is_ck;
        m_axis_tuser  <= is_ck && (crc_bad || len_bad);
      end
    end
  end

  // Per-frame status flags and saturating counters, updated when the checksum is consumed
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      frame_done    <= 1'b0;
      crc_err       <= 1'b0;
      len_err       <= 1'b0;
      frame_count   <= '0;
      crc_err_count <= '0;
      len_err_count <= '0;
    end else begin
      frame_done <= ck_acc;
      if (ck_acc) begin
        crc_err <= crc_bad;
        len_err <= len_bad;
        if (frame_count != CNT_MAX) frame_count <= frame_count + CNT_ONE;
        if (crc_bad && (crc_err_count != CNT_MAX)) crc_err_count <= crc_err_count + CNT_ONE;
        if (len_bad && (len_err_count != CNT_MAX)) len_err_count <= len_err_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_maple_rx_frame_checker.sv
// Directed bench for maple_rx_frame_checker: good, crc-bad, short, overlong
// frames, backpressure and enable stalls, mid-frame reset and counter saturation.
module tb_maple_rx_frame_checker;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        enable = 1'b1;
  logic [7:0]  s_axis_tdata = 8'h00;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        frame_done;
  logic        crc_err;
  logic        len_err;
  logic [15:0] frame_count;
  logic [15:0] crc_err_count;
  logic [15:0] len_err_count;

  maple_rx_frame_checker #(.LEN_IDX(0), .CNT_W(16)) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .frame_done(frame_done),
    .crc_err(crc_err), .len_err(len_err), .frame_count(frame_count),
    .crc_err_count(crc_err_count), .len_err_count(len_err_count)
  );

  always #5 aclk = ~aclk;

  int n_tests = 0;
  int n_fail  = 0;
  int fd_cnt  = 0;
  logic [9:0] outq[$];
  logic [9:0] exp_q[$];
  logic [7:0] in_q[$];

  // Inputs change only at posedge+1, so a handshake seen at negedge completes at the next posedge
  always @(negedge aclk) begin
    if (m_axis_tvalid && m_axis_tready) outq.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
    if (frame_done) fd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    logic ok;
    ok = 1'b0;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge aclk);
      ok = s_axis_tready;
      @(posedge aclk); #1;
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_frame();
    for (int i = 0; i < in_q.size(); i++) send_byte(in_q[i], i == in_q.size() - 1);
  endtask

  // Expected output: the first n input bytes, with tlast and the given tuser on the nth
  task automatic mk_exp(input int n, input logic u);
    exp_q.delete();
    for (int i = 0; i < n; i++)
      exp_q.push_back({(i == n - 1) ? u : 1'b0, i == n - 1, in_q[i]});
  endtask

  task automatic drain();
    for (int t = 0; t < 50 && m_axis_tvalid; t++) begin @(posedge aclk); #1; end
    if (m_axis_tvalid) chk("drain_timeout", 32'd0, 32'd1);
    repeat (2) begin @(posedge aclk); #1; end
  endtask

  task automatic check_out(input string tag);
    chk({tag, "_len"}, outq.size(), exp_q.size());
    for (int i = 0; i < outq.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), {22'd0, outq[i]}, {22'd0, exp_q[i]});
    outq.delete();
  endtask

  int fd0;

  initial begin
    #12;
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_fdone", frame_done, 0);
    chk("rst_fcount", frame_count, 0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // Good frame, len=1
    fd0 = fd_cnt;
    in_q = '{8'h01, 8'h20, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h20};
    send_frame(); drain(); mk_exp(8, 1'b0); check_out("good1");
    chk("good1_fd", fd_cnt - fd0, 1);
    chk("good1_crc", crc_err, 0);
    chk("good1_len", len_err, 0);
    chk("good1_fcount", frame_count, 1);

    // Len=0 good, then same with bad checksum
    in_q = '{8'h00, 8'h20, 8'h00, 8'h01, 8'h21};
    send_frame(); drain(); mk_exp(4, 1'b0); check_out("len0");
    chk("len0_crc", crc_err, 0);
    in_q = '{8'h00, 8'h20, 8'h00, 8'h01, 8'h22};
    send_frame(); drain(); mk_exp(4, 1'b1); check_out("badcrc");
    chk("badcrc_crc", crc_err, 1);
    chk("badcrc_len", len_err, 0);
    chk("badcrc_ccount", crc_err_count, 1);

    // Short frame with a correct XOR (01^20^00^01^AA^BB = 31)
    in_q = '{8'h01, 8'h20, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'h31};
    send_frame(); drain(); mk_exp(6, 1'b1); check_out("short");
    chk("short_len", len_err, 1);
    chk("short_crc", crc_err, 0);

    // Overlong frame: checksum found by length, tail dropped
    fd0 = fd_cnt;
    in_q = '{8'h00, 8'h20, 8'h00, 8'h01, 8'h21, 8'h55, 8'h66, 8'h77};
    send_frame(); drain(); mk_exp(4, 1'b1); check_out("long");
    chk("long_len", len_err, 1);
    chk("long_fd", fd_cnt - fd0, 1);
    chk("long_lcount", len_err_count, 2);
    in_q = '{8'h00, 8'h20, 8'h00, 8'h01, 8'h21};
    send_frame(); drain(); mk_exp(4, 1'b0); check_out("after_long");
    chk("after_long_len", len_err, 0);
    chk("after_long_fcount", frame_count, 6);

    // Single-byte frame: nothing emitted
    fd0 = fd_cnt;
    in_q = '{8'h00};
    send_frame(); drain(); exp_q.delete(); check_out("single");
    chk("single_len", len_err, 1);
    chk("single_fd", fd_cnt - fd0, 1);

    // Output backpressure mid-frame
    in_q = '{8'h01, 8'h20, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h20};
    fork
      send_frame();
      begin
        repeat (3) @(posedge aclk); #1;
        m_axis_tready = 1'b0;
        @(negedge aclk);
        chk("bp_rdy_low", s_axis_tready, 0);
        repeat (10) @(posedge aclk); #1;
        m_axis_tready = 1'b1;
      end
    join
    drain(); mk_exp(8, 1'b0); check_out("bp");
    chk("bp_crc", crc_err, 0);

    // Enable low mid-frame
    fork
      send_frame();
      begin
        repeat (4) @(posedge aclk); #1;
        enable = 1'b0;
        @(negedge aclk);
        chk("en_rdy_low", s_axis_tready, 0);
        repeat (5) @(posedge aclk); #1;
        enable = 1'b1;
      end
    join
    drain(); mk_exp(8, 1'b0); check_out("en");
    chk("en_len", len_err, 0);

    // Reset after three header bytes
    fd0 = fd_cnt;
    send_byte(8'h01, 1'b0); send_byte(8'h20, 1'b0); send_byte(8'h00, 1'b0);
    aresetn = 1'b0;
    #2;
    chk("mid_rst_tvalid", m_axis_tvalid, 0);
    chk("mid_rst_fcount", frame_count, 0);
    chk("mid_rst_lcount", len_err_count, 0);
    chk("mid_rst_crc", crc_err, 0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    repeat (3) begin @(posedge aclk); #1; end
    chk("mid_rst_fd", fd_cnt - fd0, 0);
    outq.delete();
    in_q = '{8'h01, 8'h20, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h20};
    send_frame(); drain(); mk_exp(8, 1'b0); check_out("post_rst");
    chk("post_rst_fcount", frame_count, 1);

    // 65536 single-byte bad frames saturate the counters
    s_axis_tdata  = 8'hFF;
    s_axis_tlast  = 1'b1;
    s_axis_tvalid = 1'b1;
    repeat (65536) @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (2) begin @(posedge aclk); #1; end
    chk("sat_ccount", crc_err_count, 16'hFFFF);
    chk("sat_fcount", frame_count, 16'hFFFF);
    chk("sat_lcount", len_err_count, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
